reg_wb_queue: RTL and testbench
===============================

Name: reg_wb_queue

Overview:
- Write-side companion to the pipeline register file: buffers register writebacks from the WB stage and issues them on the register file's single write port (RDaddr/RDdata/RegWrite).
- Lets the WB stage keep retiring while the write port is held by a higher-priority writer.
- Also answers "is a newer value for this register still pending?" for the RS/RT read addresses, so decode never reads a stale register.

Parameters:
- DEPTH, 4, number of queue entries (power of 2, minimum 2).
- AW, 2, pointer width; equals log2(DEPTH).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  asynchronous reset, active-low.
- wb_valid_i  in  1  writeback request valid.
- wb_addr_i  in  5  destination register.
- wb_data_i  in  32  write data.
- wb_ready_o  out  1  queue can accept a request this cycle.
- port_grant_i  in  1  write port available to this block this cycle.
- RDaddr_o  out  5  head-entry address to the register file.
- RDdata_o  out  32  head-entry data to the register file.
- RegWrite_o  out  1  head entry valid and port granted.
- rs_addr_i  in  5  RS lookup address.
- rt_addr_i  in  5  RT lookup address.
- rs_hit_o  out  1  pending write to RS exists.
- rs_data_o  out  32  youngest pending data for RS.
- rt_hit_o  out  1  pending write to RT exists.
- rt_data_o  out  32  youngest pending data for RT.
- count_o  out  AW+1  occupied entries.

Behaviour:
- Reset (rst_i=0, asynchronous): wr_ptr, rd_ptr and count are 0; all entry valid bits are 0. Outputs: RegWrite_o=0, RDaddr_o=0, RDdata_o=0, wb_ready_o=1, all hits 0, all lookup data 0, count_o=0.
- Reset mid-operation discards all pending entries; nothing is written to the register file.
- Circular FIFO with read pointer, write pointer and count; both pointers wrap modulo DEPTH.
- Accept: wb_valid_i && wb_ready_o at posedge.
  - If wb_addr_i != 0, store {addr, data} at wr_ptr and advance wr_ptr.
  - If wb_addr_i == 0, accept but do not store; this is a silent drop.
- Issue:
  - RDaddr_o and RDdata_o always show the head entry, or 0 when the queue is empty.
  - RegWrite_o = (count != 0) && port_grant_i, combinational.
  - Head pops at the posedge where RegWrite_o=1. The register file captures on the following negedge within the same cycle.
  - Throughput is one write per granted cycle.
- Latency: an accepted request into an empty queue appears on RDaddr_o/RDdata_o in the next cycle. It is written in that cycle if granted.
- Full: wb_ready_o = (count < DEPTH) || RegWrite_o. A push and a pop in the same cycle are allowed when full.
- Simultaneous push and pop: count is unchanged and both pointers advance.
  - When empty, a push and a pop never coincide, because RegWrite_o requires count != 0.
- No-grant: when port_grant_i=0 the queue holds. Entries are never reordered or merged; repeated writes to the same address are kept in order.
- Lookup (combinational over valid entries, addr != 0):
  - Hit when any valid entry's address equals the lookup address.
  - Data comes from the youngest match, i.e. closest to wr_ptr going backwards.
  - Lookup address 0 never hits.
  - The head entry being popped in the current cycle still counts as a hit in that cycle.
- Arithmetic: pointers are AW bits; count is AW+1 bits and saturates at neither end in correct use. A push when full without a pop is impossible because wb_ready_o=0.

Optional Feature:
- Macro: WB_QUEUE_LOOKUP_EN.
- Defined: the lookup logic exists exactly as described under Behaviour.
- Undefined:
  - rs_hit_o and rt_hit_o are tied to 0, and rs_data_o and rt_data_o are tied to 0; no comparators are synthesised.
  - Decode must then stall on count_o != 0.

Test Plan:
- Reset then idle: rst_i low at an arbitrary mid-cycle time -> immediately RegWrite_o=0, count_o=0, wb_ready_o=1. Release with port_grant_i=1 and no requests -> no writes.
- Single write: push addr 5 with data 32'hDEADBEEF, grant=1 -> next cycle RDaddr_o=5, RDdata_o=DEADBEEF, RegWrite_o=1 for exactly one cycle, then count_o=0.
- Fill and back-pressure: grant=0, push addresses 1, 2, 3, 4 -> count_o=4, wb_ready_o=0. Hold a 5th push -> it is not accepted. Raise grant -> writes to 1, 2, 3, 4 in order on four consecutive cycles. The 5th request is accepted in the first grant cycle and written fifth.
- $0 drop: push addr 0 with data 7 -> accepted, count_o stays 0, RegWrite_o never asserts, and an rs lookup of 0 does not hit.
- Youngest-match forwarding: grant=0, push (9, 11) then (9, 22); rs_addr_i=9 -> rs_hit_o=1, rs_data_o=22. After one grant cycle -> still a hit with 22. After two grant cycles -> hit 0.
- Full with simultaneous push and pop: with count=DEPTH and grant=1, push (6, 0x66) -> accepted, count_o stays DEPTH, and (6, 0x66) is written last in order.

Source files
------------

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: writeback FIFO for the register file write port with pending-write lookup (WB_QUEUE_LOOKUP_EN)
module reg_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wb_valid_i,
  input  logic [4:0]    wb_addr_i,
  input  logic [31:0]   wb_data_i,
  output logic          wb_ready_o,
  input  logic          port_grant_i,
  output logic [4:0]    RDaddr_o,
  output logic [31:0]   RDdata_o,
  output logic          RegWrite_o,
  input  logic [4:0]    rs_addr_i,
  input  logic [4:0]    rt_addr_i,
  output logic          rs_hit_o,
  output logic [31:0]   rs_data_o,
  output logic          rt_hit_o,
  output logic [31:0]   rt_data_o,
  output logic [AW:0]   count_o
);
  logic [4:0]       r_addr [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_nonempty;
  logic             w_push;
  logic             w_pop;
  assign w_nonempty = r_count != '0;
  assign RegWrite_o = w_nonempty && port_grant_i;
  assign wb_ready_o = (r_count < (AW+1)'(DEPTH)) || RegWrite_o;
  assign w_push     = wb_valid_i && wb_ready_o && (wb_addr_i != 5'd0);
  assign w_pop      = RegWrite_o;
  assign RDaddr_o   = w_nonempty ? r_addr[r_rd_ptr] : 5'd0;
  assign RDdata_o   = w_nonempty ? r_data[r_rd_ptr] : 32'd0;
  assign count_o    = r_count;
  // pointers, occupancy and valid bits; a push into the slot being popped keeps it valid
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_valid <= (r_valid & ~(DEPTH'(w_pop) << r_rd_ptr)) | (DEPTH'(w_push) << r_wr_ptr);
    end
  end
  // entry payload storage; contents only matter while the valid bit is set
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= wb_addr_i;
      r_data[r_wr_ptr] <= wb_data_i;
    end
  end
`ifdef WB_QUEUE_LOOKUP_EN
  function automatic logic [32:0] f_lookup(input logic [4:0] a);
    logic [32:0]   res;
    logic [AW-1:0] k;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      k = r_rd_ptr + AW'(i);
      if (r_valid[k] && (r_addr[k] == a) && (a != 5'd0)) res = {1'b1, r_data[k]};
    end
    return res;
  endfunction
  // scan oldest to youngest so the last match wins
  always_comb begin
    {rs_hit_o, rs_data_o} = f_lookup(rs_addr_i);
    {rt_hit_o, rt_data_o} = f_lookup(rt_addr_i);
  end
`else
  logic w_unused;
  assign w_unused  = ^{rs_addr_i, rt_addr_i, r_valid};
  assign rs_hit_o  = 1'b0;
  assign rs_data_o = 32'd0;
  assign rt_hit_o  = 1'b0;
  assign rt_data_o = 32'd0;
`endif
endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue: table-driven check of reg_wb_queue plus reset sequences
module tb_reg_wb_queue;
`ifdef WB_QUEUE_LOOKUP_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_valid_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        wb_ready_o;
  logic        port_grant_i;
  logic [4:0]  RDaddr_o;
  logic [31:0] RDdata_o;
  logic        RegWrite_o;
  logic [4:0]  rs_addr_i;
  logic [4:0]  rt_addr_i;
  logic        rs_hit_o;
  logic [31:0] rs_data_o;
  logic        rt_hit_o;
  logic [31:0] rt_data_o;
  logic [2:0]  count_o;
  int n_vec = 0;
  int n_bad = 0;

  reg_wb_queue #(.DEPTH(4), .AW(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
    .wb_data_i(wb_data_i), .wb_ready_o(wb_ready_o), .port_grant_i(port_grant_i),
    .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o), .RegWrite_o(RegWrite_o),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rs_hit_o(rs_hit_o),
    .rs_data_o(rs_data_o), .rt_hit_o(rt_hit_o), .rt_data_o(rt_data_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic v; logic [4:0] a; logic [31:0] d; logic g; logic [4:0] rs; logic [4:0] rt;
    logic rdy; logic we; logic [4:0] ra; logic [31:0] rd; logic [2:0] cnt;
    logic rsh; logic [31:0] rsd; logic rth; logic [31:0] rtd;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d, input logic g,
                       input logic [4:0] rs, input logic [4:0] rt);
    wb_valid_i = v; wb_addr_i = a; wb_data_i = d; port_grant_i = g; rs_addr_i = rs; rt_addr_i = rt;
  endtask

  initial begin
    //                v  a      d             g  rs     rt      rdy we ra     rd            cnt  rsh rsd           rth rtd
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd5, 5'd5,  1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 3'd1, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd5, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd1,  32'h11,       1'b0, 5'd0, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd2,  32'h22,       1'b0, 5'd0, 5'd0,  1'b1, 1'b0, 5'd1,  32'h11,       3'd1, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd3,  32'h33,       1'b0, 5'd1, 5'd0,  1'b1, 1'b0, 5'd1,  32'h11,       3'd2, 1'b1, 32'h11,       1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd4,  32'h44,       1'b0, 5'd0, 5'd0,  1'b1, 1'b0, 5'd1,  32'h11,       3'd3, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd5,  32'h55,       1'b0, 5'd4, 5'd0,  1'b0, 1'b0, 5'd1,  32'h11,       3'd4, 1'b1, 32'h44,       1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd5,  32'h55,       1'b1, 5'd4, 5'd0,  1'b1, 1'b1, 5'd1,  32'h11,       3'd4, 1'b1, 32'h44,       1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd5, 5'd0,  1'b1, 1'b1, 5'd2,  32'h22,       3'd4, 1'b1, 32'h55,       1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  1'b1, 1'b1, 5'd3,  32'h33,       3'd3, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  1'b1, 1'b1, 5'd4,  32'h44,       3'd2, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  1'b1, 1'b1, 5'd5,  32'h55,       3'd1, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd0,  32'h7,        1'b1, 5'd0, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd9,  32'd11,       1'b0, 5'd9, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd9,  32'd22,       1'b0, 5'd9, 5'd0,  1'b1, 1'b0, 5'd9,  32'd11,       3'd1, 1'b1, 32'd11,       1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd9, 5'd0,  1'b1, 1'b0, 5'd9,  32'd11,       3'd2, 1'b1, 32'd22,       1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd0,  1'b1, 1'b1, 5'd9,  32'd11,       3'd2, 1'b1, 32'd22,       1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd0,  1'b1, 1'b1, 5'd9,  32'd22,       3'd1, 1'b1, 32'd22,       1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd7,  32'h70,       1'b0, 5'd0, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd8,  32'h80,       1'b0, 5'd0, 5'd0,  1'b1, 1'b0, 5'd7,  32'h70,       3'd1, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd10, 32'hA0,       1'b0, 5'd0, 5'd0,  1'b1, 1'b0, 5'd7,  32'h70,       3'd2, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd11, 32'hB0,       1'b0, 5'd0, 5'd0,  1'b1, 1'b0, 5'd7,  32'h70,       3'd3, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b1, 5'd6,  32'h66,       1'b1, 5'd6, 5'd0,  1'b1, 1'b1, 5'd7,  32'h70,       3'd4, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd6, 5'd11, 1'b1, 1'b1, 5'd8,  32'h80,       3'd4, 1'b1, 32'h66,       1'b1, 32'hB0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  1'b1, 1'b1, 5'd10, 32'hA0,       3'd3, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  1'b1, 1'b1, 5'd11, 32'hB0,       3'd2, 1'b0, 32'h0,        1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd6, 5'd0,  1'b1, 1'b1, 5'd6,  32'h66,       3'd1, 1'b1, 32'h66,       1'b0, 32'h0});
    tbl.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0,  1'b1, 1'b0, 5'd0,  32'h0,        3'd0, 1'b0, 32'h0,        1'b0, 32'h0});

    rst_i = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    #3 rst_i = 1'b0;
    #1;
    chk("rst_we", 0, 32'(RegWrite_o), 32'd0);
    chk("rst_cnt", 0, 32'(count_o), 32'd0);
    chk("rst_rdy", 0, 32'(wb_ready_o), 32'd1);
    chk("rst_ra", 0, 32'(RDaddr_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk_i);
      drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].g, tbl[i].rs, tbl[i].rt);
      #2;
      chk("ready", i, 32'(wb_ready_o), 32'(tbl[i].rdy));
      chk("regwrite", i, 32'(RegWrite_o), 32'(tbl[i].we));
      chk("rdaddr", i, 32'(RDaddr_o), 32'(tbl[i].ra));
      chk("rddata", i, RDdata_o, tbl[i].rd);
      chk("count", i, 32'(count_o), 32'(tbl[i].cnt));
      chk("rs_hit", i, 32'(rs_hit_o), LK ? 32'(tbl[i].rsh) : 32'd0);
      chk("rs_data", i, rs_data_o, LK ? tbl[i].rsd : 32'd0);
      chk("rt_hit", i, 32'(rt_hit_o), LK ? 32'(tbl[i].rth) : 32'd0);
      chk("rt_data", i, rt_data_o, LK ? tbl[i].rtd : 32'd0);
    end

    @(negedge clk_i);
    drive(1'b1, 5'd12, 32'hC, 1'b0, 5'd12, 5'd0);
    @(negedge clk_i);
    drive(1'b1, 5'd13, 32'hD, 1'b0, 5'd12, 5'd0);
    @(negedge clk_i);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd12, 5'd0);
    #2;
    chk("mid_cnt", 0, 32'(count_o), 32'd2);
    chk("mid_ra", 0, 32'(RDaddr_o), 32'd12);
    chk("mid_hit", 0, 32'(rs_hit_o), LK ? 32'd1 : 32'd0);
    #1 rst_i = 1'b0;
    port_grant_i = 1'b1;
    #1;
    chk("mid_rst_cnt", 0, 32'(count_o), 32'd0);
    chk("mid_rst_we", 0, 32'(RegWrite_o), 32'd0);
    chk("mid_rst_rdy", 0, 32'(wb_ready_o), 32'd1);
    chk("mid_rst_hit", 0, 32'(rs_hit_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #2;
      chk("post_rst_we", i, 32'(RegWrite_o), 32'd0);
      chk("post_rst_ra", i, 32'(RDaddr_o), 32'd0);
      chk("post_rst_cnt", i, 32'(count_o), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
